// File: rtl/shift_add_multiplier.sv
// ============================================================================
// Module      : shift_add_multiplier
// Description : Radix-2 sequential multiplier for MUL/MULH/MULHSU/MULHU,
//               one multiplier bit per cycle, fixed 33-edge latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_multiplier #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [1:0]      op,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] f
);

  localparam int          CW        = $clog2(XLEN) + 1;
  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_CALC    = 2'd1;
  localparam logic [1:0]  S_FIX     = 2'd2;
  localparam logic [1:0]  OP_MUL    = 2'd0;
  localparam logic [1:0]  OP_MULH   = 2'd1;
  localparam logic [1:0]  OP_MULHSU = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [1:0]        r_op;
  logic              r_sign_a;
  logic              r_sign_b;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [2*XLEN-1:0] r_acc;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_f;
  logic              r_done;

  logic              w_sign_a;
  logic              w_sign_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_last;
  logic [2*XLEN-1:0] w_acc_fix;

  assign w_sign_a  = a[XLEN-1] & ((op == OP_MULH) | (op == OP_MULHSU));
  assign w_sign_b  = b[XLEN-1] & (op == OP_MULH);
  // Negating the most negative value yields itself, which is its true magnitude unsigned.
  assign w_mag_a   = w_sign_a ? (~a + 1'b1) : a;
  assign w_mag_b   = w_sign_b ? (~b + 1'b1) : b;
  assign w_last    = (r_cnt == CW'(XLEN - 1));
  assign w_acc_fix = (r_sign_a ^ r_sign_b) ? (~r_acc + 1'b1) : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_nxt = start ? S_CALC : S_IDLE;
      S_CALC:  w_state_nxt = w_last ? S_FIX : S_CALC;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= 2'd0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_f      <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op     <= op;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_CALC: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_f    <= (r_op == OP_MUL) ? w_acc_fix[XLEN-1:0] : w_acc_fix[2*XLEN-1:XLEN];
          r_done <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign f    = r_f;
  assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
// ============================================================================
// Module      : tb_shift_add_multiplier
// Description : Scoreboard bench for shift_add_multiplier against a plain
//               arithmetic reference of the RISC-V M multiply family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_add_multiplier;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] f;

  typedef struct {
    logic [31:0] f;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  logic prev_done = 1'b0;

  shift_add_multiplier #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .op    (op),
    .start (start),
    .busy  (busy),
    .done  (done),
    .f     (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_mul(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic [1:0] mop);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (mop == 2'd1 || mop == 2'd2) ? {{32{ma[31]}}, ma} : {32'h0, ma};
    eb = (mop == 2'd1) ? {{32{mb[31]}}, mb} : {32'h0, mb};
    p  = ea * eb;
    return (mop == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request, on time.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done <= 1'b0;
    end else begin
      prev_done <= done;
      if (done) begin
        if (prev_done) begin
          tests++;
          fails++;
          $display("FAIL done_width: done high two cycles in a row at cycle %0d", cyc);
        end
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: done=1 at cycle %0d with nothing outstanding", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", {32'h0, f}, {32'h0, e.f});
          chk("latency", 64'(cyc), 64'(e.due));
          chk("busy_in_done", {63'h0, busy}, 64'h0);
        end
      end
    end
  end

  // Issue one request at the current negedge and return at the negedge of its done cycle.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_b, input logic [1:0] top,
                        input bit noisy, input int inj_at);
    exp_t e;
    a     = ta;
    b     = tb_b;
    op    = top;
    start = 1'b1;
    e.f   = ref_mul(ta, tb_b, top);
    e.due = cyc + 34;
    q.push_back(e);
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("busy_calc", {63'h0, busy}, 64'h1);
        chk("done_calc", {63'h0, done}, 64'h0);
      end
      if (i == 32) chk("busy_fix", {63'h0, busy}, 64'h1);
      if (i == inj_at) begin
        a     = 32'd9;
        b     = 32'd9;
        op    = 2'd0;
        start = 1'b1;
      end else if (noisy && i < 33) begin
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom_range(0, 3));
        start = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    op    = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_f", {32'h0, f}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'd7, 32'hFFFF_FFFD, 2'd0, 1'b0, -1);
    run_op(32'h8000_0000, 32'h8000_0000, 2'd1, 1'b0, -1);
    run_op(32'hFFFF_FFFF, 32'd1, 2'd1, 1'b0, -1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 1'b0, -1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 1'b0, -1);
    run_op(32'd3, 32'd5, 2'd0, 1'b0, 5);
    run_op(32'd9, 32'd9, 2'd0, 1'b0, -1);

    for (int k = 0; k < 4; k++) begin
      run_op(32'h0, $urandom | 32'h1, 2'(k), 1'b0, -1);
      run_op($urandom | 32'h1, 32'h0, 2'(k), 1'b0, -1);
    end

    for (int k = 0; k < 24; k++) begin
      run_op(pick(), pick(), 2'($urandom_range(0, 3)), 1'b1, -1);
    end

    // Abort mid-CALC with an asynchronous reset; the dropped request must never complete.
    a     = $urandom;
    b     = $urandom;
    op    = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'h0, busy}, 64'h0);
    chk("abort_done", {63'h0, done}, 64'h0);
    chk("abort_f", {32'h0, f}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_abort_f", {32'h0, f}, 64'h0);

    run_op(32'h1234_5678, 32'h9ABC_DEF0, 2'd2, 1'b0, -1);
    run_op(32'hDEAD_BEEF, 32'h0000_0010, 2'd0, 1'b0, -1);

    @(negedge clk);
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d results never arrived, expected 0 outstanding", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
